// File: rtl/atm_functions.sv
// Account/PIN database and single-cycle transaction engine for the ATM controller.
// Holds NUM_ACC accounts and answers lookups combinationally; requests complete one cycle after op_valid.
module atm_functions #(
  parameter int NUM_ACC = 10,
  parameter int PIN_W   = 14,
  parameter int AMT_W   = 16,
  parameter int BAL_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       acc_num,
  input  logic [PIN_W-1:0] pin,
  input  logic [PIN_W-1:0] new_pin,
  input  logic [2:0]       operation,
  input  logic [AMT_W-1:0] amount,
  input  logic             op_valid,
  output logic [3:0]       acc_index,
  output logic             acc_found,
  output logic             acc_auth,
  output logic [BAL_W-1:0] balance,
  output logic             success,
  output logic             done
);

  localparam logic [2:0]       OP_BALANCE    = 3'd3;
  localparam logic [2:0]       OP_WITHDRAW   = 3'd4;
  localparam logic [2:0]       OP_DEPOSIT    = 3'd5;
  localparam logic [2:0]       OP_CHANGE_PIN = 3'd6;
  localparam logic [3:0]       NUM_ACC_L     = 4'(NUM_ACC);
  localparam logic [PIN_W-1:0] PIN_MAX       = PIN_W'(9999);

  logic [PIN_W-1:0] pin_db [NUM_ACC];
  logic [BAL_W-1:0] bal_db [NUM_ACC];

  logic [BAL_W-1:0] cur_bal;
  logic [BAL_W-1:0] amt_ext;
  logic [BAL_W:0]   dep_sum;
  logic [BAL_W-1:0] upd_bal;
  logic [PIN_W-1:0] upd_pin;
  logic             bal_we;
  logic             pin_we;
  logic             op_ok;

  // Lookup path: unknown account numbers map to index 0 but never authenticate.
  always_comb begin
    acc_found = (acc_num < NUM_ACC_L);
    acc_index = acc_found ? acc_num : 4'd0;
    acc_auth  = acc_found && (pin_db[acc_index] == pin);
  end

  // Request handshake: op_valid is a one-cycle strobe with no backpressure; every
  // strobe is accepted at the rising edge and answered by done=1 on the next cycle.
  always_comb begin
    cur_bal = bal_db[acc_index];
    amt_ext = {{(BAL_W-AMT_W){1'b0}}, amount};
    dep_sum = {1'b0, cur_bal} + {1'b0, amt_ext};
    upd_bal = cur_bal;
    upd_pin = pin_db[acc_index];
    bal_we  = 1'b0;
    pin_we  = 1'b0;
    op_ok   = 1'b0;
    if (op_valid && acc_auth) begin
      case (operation)
        OP_BALANCE: op_ok = 1'b1;
        OP_WITHDRAW: begin
          if (amt_ext <= cur_bal) begin
            upd_bal = cur_bal - amt_ext;
            bal_we  = 1'b1;
            op_ok   = 1'b1;
          end
        end
        OP_DEPOSIT: begin
          if (!dep_sum[BAL_W]) begin
            upd_bal = dep_sum[BAL_W-1:0];
            bal_we  = 1'b1;
            op_ok   = 1'b1;
          end
        end
        OP_CHANGE_PIN: begin
          if (new_pin <= PIN_MAX) begin
            upd_pin = new_pin;
            pin_we  = 1'b1;
            op_ok   = 1'b1;
          end
        end
        default: op_ok = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_ACC; k++) begin
        pin_db[k] <= PIN_W'(1000 + k);
        bal_db[k] <= BAL_W'(1000 * (k + 1));
      end
      balance <= '0;
      success <= 1'b0;
      done    <= 1'b0;
    end else begin
      if (bal_we) bal_db[acc_index] <= upd_bal;
      if (pin_we) pin_db[acc_index] <= upd_pin;
      // Shows the post-update value so the result lines up with done.
      balance <= acc_found ? upd_bal : '0;
      done    <= op_valid;
      if (op_valid) success <= op_ok;
    end
  end

endmodule

// File: tb/tb_atm_functions.sv
// Directed bench for atm_functions: lookup, each transaction type, overflow
// boundaries, PIN change and reset during a strobe.
module tb_atm_functions;

  logic        clk;
  logic        rst;
  logic [3:0]  acc_num;
  logic [13:0] pin;
  logic [13:0] new_pin;
  logic [2:0]  operation;
  logic [15:0] amount;
  logic        op_valid;
  logic [3:0]  acc_index;
  logic        acc_found;
  logic        acc_auth;
  logic [31:0] balance;
  logic        success;
  logic        done;

  int tests_run = 0;
  int tests_failed = 0;

  atm_functions dut (
    .clk       (clk),
    .rst       (rst),
    .acc_num   (acc_num),
    .pin       (pin),
    .new_pin   (new_pin),
    .operation (operation),
    .amount    (amount),
    .op_valid  (op_valid),
    .acc_index (acc_index),
    .acc_found (acc_found),
    .acc_auth  (acc_auth),
    .balance   (balance),
    .success   (success),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)", tag, obs, obs, exp, exp);
    end
  endtask

  // One strobed request; outputs are sampled just after the completing edge.
  task automatic do_op(input logic [3:0] a, input logic [13:0] p, input logic [2:0] op,
                       input logic [15:0] amt, input logic [13:0] np);
    acc_num   = a;
    pin       = p;
    operation = op;
    amount    = amt;
    new_pin   = np;
    op_valid  = 1'b1;
    tick();
    op_valid  = 1'b0;
  endtask

  initial begin
    rst = 1'b0; acc_num = 4'd0; pin = 14'd0; new_pin = 14'd0;
    operation = 3'd0; amount = 16'd0; op_valid = 1'b0;
    tick();
    tick();
    chk("reset_balance", balance, 32'd0);
    chk("reset_success", {31'd0, success}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    rst = 1'b1;

    // Lookup and authentication
    acc_num = 4'd2; pin = 14'd1002; #1;
    chk("acc2_found", {31'd0, acc_found}, 32'd1);
    chk("acc2_auth", {31'd0, acc_auth}, 32'd1);
    chk("acc2_index", {28'd0, acc_index}, 32'd2);
    tick();
    chk("acc2_balance", balance, 32'd3000);
    chk("acc2_idle_done", {31'd0, done}, 32'd0);
    pin = 14'd1003; #1;
    chk("acc2_badpin_auth", {31'd0, acc_auth}, 32'd0);

    acc_num = 4'd12; pin = 14'd1002; #1;
    chk("acc12_found", {31'd0, acc_found}, 32'd0);
    chk("acc12_auth", {31'd0, acc_auth}, 32'd0);
    chk("acc12_index", {28'd0, acc_index}, 32'd0);
    tick();
    chk("acc12_balance", balance, 32'd0);
    do_op(4'd12, 14'd1002, 3'd3, 16'd0, 14'd0);
    chk("acc12_op_done", {31'd0, done}, 32'd1);
    chk("acc12_op_success", {31'd0, success}, 32'd0);

    // Withdraw, including the exact-balance boundary
    do_op(4'd0, 14'd1000, 3'd4, 16'd400, 14'd0);
    chk("wd400_balance", balance, 32'd600);
    chk("wd400_success", {31'd0, success}, 32'd1);
    chk("wd400_done", {31'd0, done}, 32'd1);
    tick();
    chk("idle_done_low", {31'd0, done}, 32'd0);
    chk("idle_success_hold", {31'd0, success}, 32'd1);
    do_op(4'd0, 14'd1000, 3'd4, 16'd700, 14'd0);
    chk("wd700_balance", balance, 32'd600);
    chk("wd700_success", {31'd0, success}, 32'd0);
    do_op(4'd0, 14'd1000, 3'd4, 16'd600, 14'd0);
    chk("wd600_balance", balance, 32'd0);
    chk("wd600_success", {31'd0, success}, 32'd1);
    do_op(4'd2, 14'd1003, 3'd4, 16'd100, 14'd0);
    chk("wd_badpin_balance", balance, 32'd3000);
    chk("wd_badpin_success", {31'd0, success}, 32'd0);
    chk("wd_badpin_done", {31'd0, done}, 32'd1);

    // Deposit and 32-bit overflow boundary; back-to-back strobes build up the balance
    do_op(4'd9, 14'd1009, 3'd5, 16'd65535, 14'd0);
    chk("dep_max_balance", balance, 32'd75535);
    chk("dep_max_success", {31'd0, success}, 32'd1);
    op_valid = 1'b1;
    amount = 16'd65535;
    repeat (65535) tick();
    amount = 16'd55520;
    tick();
    op_valid = 1'b0;
    chk("dep_fill_balance", balance, 32'hFFFF_FFF0);
    chk("dep_fill_success", {31'd0, success}, 32'd1);
    do_op(4'd9, 14'd1009, 3'd5, 16'h0020, 14'd0);
    chk("dep_ovf_balance", balance, 32'hFFFF_FFF0);
    chk("dep_ovf_success", {31'd0, success}, 32'd0);
    do_op(4'd9, 14'd1009, 3'd5, 16'h000F, 14'd0);
    chk("dep_top_balance", balance, 32'hFFFF_FFFF);
    chk("dep_top_success", {31'd0, success}, 32'd1);
    do_op(4'd9, 14'd1009, 3'd5, 16'h0001, 14'd0);
    chk("dep_ovf1_balance", balance, 32'hFFFF_FFFF);
    chk("dep_ovf1_success", {31'd0, success}, 32'd0);
    do_op(4'd9, 14'd1009, 3'd3, 16'd0, 14'd0);
    chk("bal_inq_success", {31'd0, success}, 32'd1);
    chk("bal_inq_balance", balance, 32'hFFFF_FFFF);
    do_op(4'd9, 14'd1009, 3'd7, 16'd5, 14'd0);
    chk("noop_success", {31'd0, success}, 32'd0);
    chk("noop_balance", balance, 32'hFFFF_FFFF);

    // PIN change
    do_op(4'd1, 14'd1001, 3'd6, 16'd0, 14'd4321);
    chk("chpin_success", {31'd0, success}, 32'd1);
    chk("chpin_balance", balance, 32'd2000);
    pin = 14'd1001; #1;
    chk("chpin_old_auth", {31'd0, acc_auth}, 32'd0);
    pin = 14'd4321; #1;
    chk("chpin_new_auth", {31'd0, acc_auth}, 32'd1);
    do_op(4'd1, 14'd4321, 3'd6, 16'd0, 14'd12000);
    chk("chpin_bad_success", {31'd0, success}, 32'd0);
    #1;
    chk("chpin_bad_keeps_auth", {31'd0, acc_auth}, 32'd1);
    do_op(4'd1, 14'd4321, 3'd6, 16'd0, 14'd9999);
    chk("chpin_9999_success", {31'd0, success}, 32'd1);
    pin = 14'd9999; #1;
    chk("chpin_9999_auth", {31'd0, acc_auth}, 32'd1);

    // Reset arriving with a withdraw strobe
    acc_num = 4'd2; pin = 14'd1002; operation = 3'd4; amount = 16'd100;
    op_valid = 1'b1; rst = 1'b0;
    tick();
    chk("rst_strobe_done", {31'd0, done}, 32'd0);
    chk("rst_strobe_success", {31'd0, success}, 32'd0);
    chk("rst_strobe_balance", balance, 32'd0);
    op_valid = 1'b0; rst = 1'b1;
    tick();
    chk("rst_acc2_balance", balance, 32'd3000);
    acc_num = 4'd0; pin = 14'd1000;
    tick();
    chk("rst_acc0_balance", balance, 32'd1000);
    acc_num = 4'd9; pin = 14'd1009;
    tick();
    chk("rst_acc9_balance", balance, 32'd10000);
    acc_num = 4'd1; pin = 14'd1001; #1;
    chk("rst_acc1_pin_auth", {31'd0, acc_auth}, 32'd1);
    pin = 14'd9999; #1;
    chk("rst_acc1_newpin_auth", {31'd0, acc_auth}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    tests_failed++;
    $display("FAIL timeout: simulation exceeded time budget");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "timeout");
  end

endmodule
